// File: rtl/spi_req_scheduler_if.sv
// Requester and SPI-master signals shared by the round-robin SPI request scheduler.
// Pure wiring, no latency; requesters hold req until done (level handshake).
// The scheduler uses the slave modport; clients and the SPI master side use master.
interface spi_req_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ*3-1:0]  req_mode;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               err;
    logic [DW-1:0]      rx_data;
    logic               busy;
    logic               m_enable;
    logic [DW-1:0]      m_data;
    logic [2:0]         m_mode;
    logic               m_le;
    logic               m_te;
    logic               m_miso;

    modport master (
        output req, req_data, req_mode, m_le, m_te, m_miso,
        input  grant, done, err, rx_data, busy, m_enable, m_data, m_mode
    );

    modport slave (
        input  req, req_data, req_mode, m_le, m_te, m_miso,
        output grant, done, err, rx_data, busy, m_enable, m_data, m_mode
    );
endinterface

// File: rtl/spi_req_scheduler.sv
// Round-robin scheduler sharing one SPI master among NREQ requesters; SPI_GAP_EN adds a deselect gap.
// Latency: req in IDLE -> m_enable 2 cycles later; done 1 cycle after the DW-th sample edge.
// Backpressure: requesters hold req until their done pulse; the bus stays busy until DONE (or GAP) ends.
module spi_req_scheduler #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TMO_CYC = 1023,
    parameter int GAP_CYC = 4
) (
    input  logic               clk,
    input  logic               reset,
    spi_req_scheduler_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(DW + 1);

    generate
        if (NREQ < 2 || NREQ > 8 || GAP_CYC < 1 || TMO_CYC > 1023) begin : g_param_chk
            $error("spi_req_scheduler: parameter out of range");
        end
    endgenerate

`ifdef SPI_GAP_EN
    localparam int GW = $clog2(GAP_CYC + 1);
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_XFER, S_DONE, S_GAP} state_t;
    logic [GW-1:0] gap_cnt;
`else
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_XFER, S_DONE} state_t;
`endif

    state_t          state, state_nxt;
    logic [PW-1:0]   rr_ptr, owner, pick_idx;
    logic            pick_vld;
    logic [NREQ-1:0] grant_q;
    logic [DW-1:0]   m_data_q, rx_data_q, shreg;
    logic [2:0]      m_mode_q;
    logic [BW-1:0]   bit_cnt;
    logic [9:0]      tmo_cnt;
    logic            tmo_flag;
    logic            samp, last_bit, tmo_hit;

    // Descending scan so the lowest offset from rr_ptr is written last and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[(int'(rr_ptr) + i) % NREQ]) begin
                pick_vld = 1'b1;
                pick_idx = PW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    assign samp     = (state == S_XFER) && (m_mode_q[0] ? bus.m_te : bus.m_le);
    assign last_bit = samp && (bit_cnt == BW'(DW - 1));
    assign tmo_hit  = (state == S_XFER) && (tmo_cnt == 10'(TMO_CYC));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|bus.req) state_nxt = S_ARB;
            S_ARB:   state_nxt = pick_vld ? S_LOAD : S_IDLE;
            S_LOAD:  state_nxt = S_XFER;
            S_XFER:  if (last_bit || tmo_hit) state_nxt = S_DONE;
`ifdef SPI_GAP_EN
            S_DONE:  state_nxt = S_GAP;
            S_GAP:   if (gap_cnt == GW'(GAP_CYC - 1)) state_nxt = S_IDLE;
`else
            S_DONE:  state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.m_enable = (state == S_LOAD) || (state == S_XFER);
        bus.busy     = (state != S_IDLE) && (state != S_ARB);
        bus.done     = (state == S_DONE) ? grant_q : '0;
        bus.err      = (state == S_DONE) && tmo_flag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            owner     <= '0;
            grant_q   <= '0;
            m_data_q  <= '0;
            m_mode_q  <= '0;
            rx_data_q <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            tmo_flag  <= 1'b0;
`ifdef SPI_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_ARB: begin
                    if (pick_vld) begin
                        owner    <= pick_idx;
                        grant_q  <= NREQ'(1) << pick_idx;
                        m_data_q <= bus.req_data[int'(pick_idx)*DW +: DW];
                        m_mode_q <= bus.req_mode[int'(pick_idx)*3 +: 3];
                    end
                end
                S_LOAD: begin
                    bit_cnt  <= '0;
                    tmo_cnt  <= '0;
                    shreg    <= '0;
                    tmo_flag <= 1'b0;
                end
                S_XFER: begin
                    tmo_cnt <= tmo_cnt + 10'd1;
                    if (samp) begin
                        shreg   <= {shreg[DW-2:0], bus.m_miso};
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                    // A completing sample beats a same-cycle timeout.
                    if (last_bit) begin
                        rx_data_q <= {shreg[DW-2:0], bus.m_miso};
                    end else if (tmo_hit) begin
                        rx_data_q <= '0;
                        tmo_flag  <= 1'b1;
                    end
                end
                S_DONE: begin
                    grant_q <= '0;
                    rr_ptr  <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
`ifdef SPI_GAP_EN
                    gap_cnt <= '0;
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.grant   = grant_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_mode  = m_mode_q;
    assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_req_scheduler.sv
// Directed bench for spi_req_scheduler with a behavioural SPI master strobe/MISO model.
// Latency: checks taken #1 after each rising edge; expected values hand-computed.
// Backpressure: requesters hold req until done, then drop it via a per-call mask.
module tb_spi_req_scheduler;
    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TMO_CYC = 1023;
    localparam int GAP_CYC = 4;
`ifdef SPI_GAP_EN
    localparam int EXP_WAIT = 2 + GAP_CYC;
    localparam int EXP_GAP  = GAP_CYC;
`else
    localparam int EXP_WAIT = 2;
    localparam int EXP_GAP  = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_req_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

    spi_req_scheduler #(.NREQ(NREQ), .DW(DW), .TMO_CYC(TMO_CYC), .GAP_CYC(GAP_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors      = 0;
    int checks      = 0;
    int done_pulses = 0;
    int gap_cyc     = 0;
    int wait_cyc    = 0;

    always @(negedge clk) begin
        if (|bus.done) done_pulses++;
        if (!reset && bus.busy && !bus.m_enable && bus.done == '0) gap_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic done_chk(input int who, input logic exp_err, input logic [7:0] exp_rx,
                            input logic [3:0] drop_mask);
        check("done_vec", bus.done, 32'(1) << who);
        check("err", bus.err, exp_err);
        check("rx_data", bus.rx_data, exp_rx);
        check("en_low_done", bus.m_enable, 0);
        check("busy_done", bus.busy, 1);
        bus.req = bus.req & ~drop_mask;
    endtask

    task automatic set_req(input int who, input logic [7:0] tx, input logic [2:0] mode);
        bus.req_data[who*DW +: DW] = tx;
        bus.req_mode[who*3 +: 3]   = mode;
        bus.req[who]               = 1'b1;
    endtask

    // Serves one transfer for the expected owner; mode 1 drives a wrong MISO bit on le.
    task automatic xfer(input int who, input logic [2:0] mode, input logic [7:0] tx,
                        input logic [7:0] miso_b, input logic stall, input logic [3:0] drop_mask);
        int n;
        logic [7:0] exp_rx;
        exp_rx = stall ? 8'h00 : miso_b;
        n = 0;
        while (!bus.m_enable && n < 40) begin
            tick();
            n++;
        end
        wait_cyc = n;
        check("en_seen", bus.m_enable, 1);
        check("grant", bus.grant, 32'(1) << who);
        check("m_data", bus.m_data, tx);
        check("m_mode", bus.m_mode, mode);
        tick();
        if (stall) begin
            n = 0;
            while (bus.done == '0 && n < 1100) begin
                tick();
                n++;
            end
            check("tmo_len", n, TMO_CYC + 1);
            done_chk(who, 1'b1, 8'h00, drop_mask);
            tick();
        end else begin
            for (int b = 7; b >= 0; b--) begin
                bus.m_le   = 1'b1;
                bus.m_te   = !mode[0];
                bus.m_miso = mode[0] ? ~miso_b[b] : miso_b[b];
                tick();
                bus.m_le = 1'b0;
                bus.m_te = 1'b0;
                if (!mode[0] && b == 0) done_chk(who, 1'b0, miso_b, drop_mask);
                bus.m_te   = 1'b1;
                bus.m_miso = miso_b[b];
                tick();
                bus.m_te = 1'b0;
                if (mode[0] && b == 0) done_chk(who, 1'b0, miso_b, drop_mask);
            end
            if (mode[0]) tick();
        end
        check("done_1cyc", bus.done, 0);
        check("grant_clr", bus.grant, 0);
        check("rx_hold", bus.rx_data, exp_rx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int p0, g0;
        bus.req = '0; bus.req_data = '0; bus.req_mode = '0;
        bus.m_le = 1'b0; bus.m_te = 1'b0; bus.m_miso = 1'b0;
        repeat (3) tick();
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_en", bus.m_enable, 0);
        check("rst_mdata", bus.m_data, 0);
        check("rst_mmode", bus.m_mode, 0);
        check("rst_rx", bus.rx_data, 0);
        reset = 1'b0;

        // single request, mode 0, with enable latency
        set_req(1, 8'hA5, 3'b000);
        tick();
        check("lat_arb_en", bus.m_enable, 0);
        check("lat_arb_busy", bus.busy, 0);
        tick();
        check("lat_load_en", bus.m_enable, 1);
        check("lat_load_busy", bus.busy, 1);
        xfer(1, 3'b000, 8'hA5, 8'h3C, 1'b0, 4'b0010);

        // all four held from rr_ptr=0
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (GAP_CYC + 2) tick();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h10 + i), 3'b000);
        p0 = done_pulses;
        g0 = gap_cyc;
        xfer(0, 3'b000, 8'h10, 8'hC1, 1'b0, 4'b0000);
        xfer(1, 3'b000, 8'h11, 8'h52, 1'b0, 4'b0000);
        check("next_en_wait", wait_cyc, EXP_WAIT);
        xfer(2, 3'b000, 8'h12, 8'hE7, 1'b0, 4'b0000);
        xfer(3, 3'b000, 8'h13, 8'h09, 1'b0, 4'b0000);
        xfer(0, 3'b000, 8'h10, 8'h6D, 1'b0, 4'b1111);
        repeat (GAP_CYC + 4) tick();
        check("rr_pulses", done_pulses - p0, 5);
        check("gap_cycles", gap_cyc - g0, 5 * EXP_GAP);
        check("idle_busy", bus.busy, 0);

        // CPHA=1 samples on te only
        set_req(2, 8'h5A, 3'b001);
        xfer(2, 3'b001, 8'h5A, 8'h81, 1'b0, 4'b0100);
        repeat (GAP_CYC + 2) tick();

        // stalled master -> timeout abort
        set_req(0, 8'h99, 3'b000);
        xfer(0, 3'b000, 8'h99, 8'h00, 1'b1, 4'b0001);
        repeat (GAP_CYC + 2) tick();

        // reset at bit_cnt=4
        set_req(3, 8'hC3, 3'b000);
        wait_cyc = 0;
        while (!bus.m_enable && wait_cyc < 40) begin
            tick();
            wait_cyc++;
        end
        check("mid_en", bus.m_enable, 1);
        tick();
        for (int b = 0; b < 4; b++) begin
            bus.m_le = 1'b1; bus.m_miso = 1'b1;
            tick();
            bus.m_le = 1'b0; bus.m_te = 1'b1;
            tick();
            bus.m_te = 1'b0;
        end
        p0 = done_pulses;
        reset = 1'b1;
        tick();
        check("mid_rst_en", bus.m_enable, 0);
        check("mid_rst_grant", bus.grant, 0);
        check("mid_rst_busy", bus.busy, 0);
        tick();
        reset = 1'b0;
        set_req(0, 8'h66, 3'b000);
        xfer(0, 3'b000, 8'h66, 8'hF0, 1'b0, 4'b0001);
        check("mid_no_done", done_pulses - p0, 1);
        xfer(3, 3'b000, 8'hC3, 8'h0F, 1'b0, 4'b1000);
        repeat (GAP_CYC + 4) tick();
        check("final_idle", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
